// File: rtl/mac_requant_pkg.sv
// Shared configuration, derived widths and the inter-stage record of the requantisation stage.
// The REQUANT_RELU_EN macro (used in requant_round_sat) selects ReLU before saturation.
package mac_requant_pkg;

  localparam int OUT_BIT   = 20;
  localparam int IN_BIT    = 8;
  localparam int BIAS_BIT  = 20;
  localparam int CH_NUM    = 16;
  localparam int SHIFT_BIT = 5;

  localparam int SUM_BIT  = ((OUT_BIT > BIAS_BIT) ? OUT_BIT : BIAS_BIT) + 1;
  localparam int R_BIT    = SUM_BIT + 1;
  localparam int CHAN_BIT = $clog2(CH_NUM);

  localparam logic signed [R_BIT-1:0] SAT_MAX = R_BIT'(2 ** (IN_BIT - 1) - 1);
  localparam logic signed [R_BIT-1:0] SAT_MIN = R_BIT'(-(2 ** (IN_BIT - 1)));

  typedef struct packed {
    logic                    valid;
    logic [CHAN_BIT-1:0]     chan;
    logic [SHIFT_BIT-1:0]    shift;
    logic signed [R_BIT-1:0] value;
  } stage_t;

  // Shift amounts past the accumulator width carry no information; pin them to the widest useful shift.
  function automatic logic [SHIFT_BIT-1:0] clamp_shift(input logic [SHIFT_BIT-1:0] s);
    return (s > SHIFT_BIT'(OUT_BIT - 1)) ? SHIFT_BIT'(OUT_BIT - 1) : s;
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Combinational helpers: round-half-up arithmetic right shift, and activation plus saturation.
// Define REQUANT_RELU_EN to clamp negative values to zero before saturating.
module requant_round_sat
  import mac_requant_pkg::*;
(
  input  logic signed [R_BIT-1:0]     sum,
  input  logic        [SHIFT_BIT-1:0] shift,
  output logic signed [R_BIT-1:0]     rounded,
  input  logic signed [R_BIT-1:0]     value,
  output logic signed [IN_BIT-1:0]   act
);

  logic signed [R_BIT-1:0] half;
  logic signed [R_BIT-1:0] relu_in;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    half = '0;
    if (shift != '0) half = R_BIT'(1) << (shift - 1'b1);
    rounded = (sum + half) >>> shift;
  end

  always_comb begin
    relu_in = value;
`ifdef REQUANT_RELU_EN
    if (value[R_BIT-1]) relu_in = '0;
`endif
    if (relu_in > SAT_MAX)      act = SAT_MAX[IN_BIT-1:0];
    else if (relu_in < SAT_MIN) act = SAT_MIN[IN_BIT-1:0];
    else                        act = relu_in[IN_BIT-1:0];
  end

endmodule

// File: rtl/mac_requant_stage.sv
// Three-stage bias / round-shift / activate-saturate pipeline behind the MAC accumulator.
// Define REQUANT_RELU_EN to enable ReLU activation in the last stage.
module mac_requant_stage
  import mac_requant_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [OUT_BIT-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic        [SHIFT_BIT-1:0] shift,
  input  logic                        bias_we,
  input  logic        [CHAN_BIT-1:0]  bias_addr,
  input  logic signed [BIAS_BIT-1:0]  bias_data,
  output logic signed [IN_BIT-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [CHAN_BIT-1:0]  out_chan,
  output logic                        out_last
);

  logic signed [BIAS_BIT-1:0] bias_mem [CH_NUM];
  logic        [CHAN_BIT-1:0] chan;
  logic                       adv;
  logic signed [SUM_BIT-1:0]  sum;

  stage_t                     s1;
  logic                       s2_valid;
  logic        [CHAN_BIT-1:0] s2_chan;
  logic signed [R_BIT-1:0]    s2_value;

  logic signed [R_BIT-1:0]    rounded;
  logic signed [IN_BIT-1:0]   act;

  // A single advance enable keeps every stage in lockstep; a stalled output freezes the whole pipe.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign sum      = SUM_BIT'(in_data) + SUM_BIT'(bias_mem[chan]);

  // NOTE: the bias table has no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (bias_we) bias_mem[bias_addr] <= bias_data;
  end

  requant_round_sat u_round_sat (
    .sum     (s1.value),
    .shift   (s1.shift),
    .rounded (rounded),
    .value   (s2_value),
    .act     (act)
  );

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2_valid  <= 1'b0;
      s2_chan   <= '0;
      s2_value  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      chan      <= '0;
    end else if (adv) begin
      s1 <= '{valid: in_valid, chan: chan, shift: clamp_shift(shift), value: R_BIT'(sum)};
      if (in_valid) chan <= (chan == CHAN_BIT'(CH_NUM - 1)) ? '0 : chan + 1'b1;

      s2_valid <= s1.valid;
      s2_chan  <= s1.chan;
      s2_value <= rounded;

      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= act;
        out_chan <= s2_chan;
        out_last <= (s2_chan == CHAN_BIT'(CH_NUM - 1));
      end
    end
  end

endmodule

// File: tb/tb_mac_requant_stage.sv
// Self-checking bench for mac_requant_stage: vector table, scoreboard queue, stall and reset sequences.
module tb_mac_requant_stage;

`ifdef REQUANT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [19:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic        [4:0]  shift = '0;
  logic               bias_we = 1'b0;
  logic        [3:0]  bias_addr = '0;
  logic signed [19:0] bias_data = '0;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic        [3:0]  out_chan;
  logic               out_last;

  mac_requant_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift     (shift),
    .bias_we   (bias_we),
    .bias_addr (bias_addr),
    .bias_data (bias_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int chan;
    bit last;
    int acc;
    bit lat;
  } exp_t;

  typedef struct {
    int din;
    int sh;
    int exp;
  } vec_t;

  exp_t   sb[$];
  vec_t   vec[18];
  longint bias_m[16];
  int     ch_m = 0;
  int     last_acc = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor((x + b + 2^(s-1)) / 2^s) using integer division, then activation and clipping.
  function automatic int model(input longint x, input longint b, input int sh);
    longint v;
    longint d;
    int     s;
    v = x + b;
    s = (sh > 19) ? 19 : sh;
    if (s > 0) begin
      d = longint'(1) << s;
      v = v + d / 2;
      v = (v >= 0) ? v / d : -((-v + d - 1) / d);
    end
    if (RELU && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic wr_bias(input int a, input longint v);
    bias_we   = 1'b1;
    bias_addr = a[3:0];
    bias_data = v[19:0];
    @(posedge clk); #1;
    bias_we   = 1'b0;
    bias_m[a] = v;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send(input int d, input int s, input int exp, input bit lat);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d[19:0];
    shift    = s[4:0];
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back('{data: exp, chan: ch_m, last: (ch_m == 15), acc: cyc, lat: lat});
        last_acc = cyc;
        ch_m = (ch_m + 1) % 16;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && sb.size() != 0; w++) begin
      @(negedge clk); #1;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard pops and stall-stability checks.
  logic              prev_stall = 1'b0;
  logic signed [7:0] prev_data;
  logic        [3:0] prev_chan;
  logic              prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_chan", out_chan, prev_chan);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_chan", out_chan, e.chan);
          check("out_last", out_last, e.last);
          if (e.lat) check("latency", cyc - e.acc, 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_chan  = out_chan;
      prev_last  = out_last;
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish before cycle 5000");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh_tab[10];
    int first_acc;
    sh_tab = '{0, 3, 7, 19, 31, 25, 1, 10, 5, 15};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Bias table
    wr_bias(0, 24);
    wr_bias(1, 0);
    wr_bias(2, 0);
    wr_bias(3, 0);
    for (int i = 4; i < 14; i++) wr_bias(i, longint'(i * 1111 - 9000));
    wr_bias(14, 524287);
    wr_bias(15, -524288);

    // Vector table: one full channel sweep plus two wrap beats
    for (int i = 0; i < 18; i++) begin
      vec[i].din = i * 37000 - 200000;
      vec[i].sh  = (i >= 4 && i < 14) ? sh_tab[i-4] : 0;
      vec[i].exp = model(vec[i].din, bias_m[i % 16], vec[i].sh);
    end
    vec[0]  = '{din: 1000,    sh: 4,  exp: 64};
    vec[1]  = '{din: 6,       sh: 2,  exp: 2};
    vec[2]  = '{din: -300,    sh: 2,  exp: RELU ? 0 : -75};
    vec[3]  = '{din: 100000,  sh: 0,  exp: 127};
    vec[8]  = '{din: 500000,  sh: 31, exp: 1};
    vec[14] = '{din: 524287,  sh: 14, exp: 64};
    vec[15] = '{din: -524288, sh: 12, exp: RELU ? 0 : -128};
    vec[16] = '{din: -1000,   sh: 3,  exp: RELU ? 0 : -122};
    vec[17] = '{din: -6,      sh: 2,  exp: RELU ? 0 : -1};

    first_acc = 0;
    for (int i = 0; i < 18; i++) begin
      send(vec[i].din, vec[i].sh, vec[i].exp, 1'b1);
      if (i == 0) first_acc = last_acc;
      else check("back_to_back_accept", last_acc - first_acc, i);
    end
    drain();

    // Stall: three beats in flight, output held for five cycles, fourth beat waits
    out_ready = 1'b0;
    send(1111, 1, model(1111, bias_m[ch_m], 1), 1'b0);
    send(-2222, 1, model(-2222, bias_m[ch_m], 1), 1'b0);
    send(3333, 1, model(3333, bias_m[ch_m], 1), 1'b0);
    fork
      send(-4444, 1, model(-4444, bias_m[ch_m], 1), 1'b0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream
    send(100000, 4, model(100000, bias_m[ch_m], 4), 1'b1);
    send(2000, 2, model(2000, bias_m[ch_m], 2), 1'b1);
    send(3000, 2, model(3000, bias_m[ch_m], 2), 1'b1);
    for (int w = 0; w < 20 && sb.size() != 2; w++) begin
      @(negedge clk); #1;
    end
    check("pre_reset_pending", sb.size(), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    ch_m = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(1000, 4, 64, 1'b1);
    drain();

    // Bias write and read of the same entry in one cycle uses the old value
    bias_we   = 1'b1;
    bias_addr = 4'd1;
    bias_data = 20'sd777;
    send(40, 4, 3, 1'b1);
    bias_we   = 1'b0;
    bias_m[1] = 777;
    for (int i = 0; i < 15; i++) send(i * 500, 2, model(i * 500, bias_m[ch_m], 2), 1'b1);
    send(40, 4, 51, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
